pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, busy cycles loaded on a multiply start.
REQ-002 Parameter DIV_CYC, default 10, busy cycles loaded on a divide start.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; state is cleared on a posedge clk where reset==0.
REQ-005 D_rs  input  5  D-stage rs register address.
REQ-006 D_rt  input  5  D-stage rt register address.
REQ-007 D_tuse_rs  input  2  D-stage cycles until rs is consumed.
REQ-008 D_tuse_rt  input  2  D-stage cycles until rt is consumed.
REQ-009 D_md  input  1  D-stage instruction uses the multiply/divide unit (mult, div, mfhi, mflo, mthi, mtlo).
REQ-010 E_waddr  input  5  E-stage destination register.
REQ-011 E_tnew  input  2  E-stage cycles until the result is available.
REQ-012 M_waddr  input  5  M-stage destination register.
REQ-013 M_tnew  input  2  M-stage cycles until the result is available.
REQ-014 E_md_start  input  1  E-stage instruction starts a mult/div this cycle.
REQ-015 E_md_div  input  1  qualifies E_md_start: 1 = divide, 0 = multiply.
REQ-016 F_WE  output  1  PC / F-to-D register write enable.
REQ-017 D_WE  output  1  D-to-E register (instr/pc/RD1/RD2/EXT32) write enable.
REQ-018 E_clr  output  1  load a bubble (all-zero instr) into the D-to-E register.
REQ-019 md_busy  output  1  mult/div unit is occupied.
REQ-020 stall_cnt  output  32  number of stall cycles since reset.

Function
REQ-021 The design SHALL keep a 4-bit down-counter md_cnt; md_busy SHALL be (md_cnt != 0).
REQ-022 When E_md_start==1, md_cnt SHALL load DIV_CYC if E_md_div==1, else MULT_CYC, on the next edge; this SHALL take priority over decrement (restart while busy reloads).
REQ-023 Otherwise, md_cnt SHALL decrement by 1 per cycle while nonzero, and SHALL hold at 0.
REQ-024 Define stall_rs = (D_rs!=0) && ((D_rs==E_waddr && E_tnew>D_tuse_rs) || (D_rs==M_waddr && M_tnew>D_tuse_rs)); stall_rt is the same with D_rt and D_tuse_rt.
REQ-025 Define stall_md = D_md && (E_md_start || md_busy).
REQ-026 stall = stall_rs || stall_rt || stall_md, combinational, same cycle as the inputs.
REQ-027 When stall==1, F_WE=0, D_WE=0 and E_clr=1; otherwise F_WE=1, D_WE=1 and E_clr=0.
REQ-028 Register address 0 SHALL never cause a stall, irrespective of waddr or tnew.
REQ-029 A simultaneous E-stage and M-stage match SHALL stall if either condition holds.
REQ-030 stall_cnt SHALL increment by 1 on each edge where stall==1 and reset==1, and SHALL saturate at 32'hFFFFFFFF.
REQ-031 The block SHALL NOT introduce any latency beyond the one-edge md_cnt load; all outputs other than md_busy and stall_cnt are purely combinational.

Reset
REQ-032 On an edge with reset==0, md_cnt and stall_cnt SHALL become 0.
REQ-033 While reset==0, the block SHALL force F_WE=1, D_WE=1, E_clr=0 and md_busy=0, regardless of the other inputs.
REQ-034 A reset asserted while md_cnt!=0 SHALL abort the count; md_busy SHALL be 0 in the cycle after that edge.
REQ-035 An E_md_start in the same cycle as reset==0 SHALL be ignored.

Verification
REQ-036 Hold reset=0 for 2 cycles with random inputs, then set reset=1 -> F_WE=D_WE=1, E_clr=0, md_busy=0, stall_cnt=0.
REQ-037 D_rs=5, D_tuse_rs=0, E_waddr=5, E_tnew=1 -> F_WE=0, D_WE=0, E_clr=1 in that cycle; repeat with D_rs=0 -> no stall.
REQ-038 Pulse E_md_start=1 with E_md_div=0 for 1 cycle, and hold D_md=1 -> md_busy=1 for exactly 5 cycles after the edge; stall asserted in the start cycle plus those 5 cycles; stall_cnt=6.
REQ-039 Pulse a divide start, then pulse a multiply start 3 cycles later -> md_cnt reloads to 5; md_busy lasts 3+5 cycles in total.
REQ-040 Set reset=0 when md_cnt=7 -> md_busy=0 on the next cycle, and stall_cnt=0.
REQ-041 Hold stall=1 with stall_cnt preloaded near saturation (force) -> stall_cnt stays at 32'hFFFFFFFF without wrapping.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard-detection inputs from the D/E/M stages and
// the resulting write-enable / bubble / multiply-divide status outputs.
interface pipe_ctrl_if;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_tuse_rs;
  logic [1:0]  D_tuse_rt;
  logic        D_md;
  logic [4:0]  E_waddr;
  logic [1:0]  E_tnew;
  logic [4:0]  M_waddr;
  logic [1:0]  M_tnew;
  logic        E_md_start;
  logic        E_md_div;
  logic        F_WE;
  logic        D_WE;
  logic        E_clr;
  logic        md_busy;
  logic [31:0] stall_cnt;

  // master: the datapath that reports stage state and obeys the enables
  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md,
           E_waddr, E_tnew, M_waddr, M_tnew, E_md_start, E_md_div,
    input  F_WE, D_WE, E_clr, md_busy, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md,
           E_waddr, E_tnew, M_waddr, M_tnew, E_md_start, E_md_div,
    output F_WE, D_WE, E_clr, md_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: Tuse/Tnew data hazards,
// multiply/divide occupancy tracking and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.slave  bus
);

  localparam logic [3:0]  MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0]  DIV_LOAD  = 4'(DIV_CYC);
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt_q;
  logic        md_busy;
  logic        stall_rs;
  logic        stall_rt;
  logic        stall_md;
  logic        stall;

  // Busy and every stall term are gated by reset so the pipeline free-runs
  // while reset is held, whatever the stage inputs say.
  assign md_busy = reset && (md_cnt != 4'd0);

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    stall_md = 1'b0;
    if (reset) begin
      stall_rs = (bus.D_rs != 5'd0) &&
                 ((bus.D_rs == bus.E_waddr && bus.E_tnew > bus.D_tuse_rs) ||
                  (bus.D_rs == bus.M_waddr && bus.M_tnew > bus.D_tuse_rs));
      stall_rt = (bus.D_rt != 5'd0) &&
                 ((bus.D_rt == bus.E_waddr && bus.E_tnew > bus.D_tuse_rt) ||
                  (bus.D_rt == bus.M_waddr && bus.M_tnew > bus.D_tuse_rt));
      stall_md = bus.D_md && (bus.E_md_start || md_busy);
    end
    stall = stall_rs || stall_rt || stall_md;
  end

  assign bus.F_WE      = !stall;
  assign bus.D_WE      = !stall;
  assign bus.E_clr     = stall;
  assign bus.md_busy   = md_busy;
  assign bus.stall_cnt = stall_cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt <= 4'd0;
    end else if (bus.E_md_start) begin
      // A new start always wins, even over a unit that is still counting.
      md_cnt <= bus.E_md_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && stall_cnt_q != CNT_MAX) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: reset behaviour, data hazards,
// multiply/divide occupancy, restart, reset abort and counter saturation.
module tb_pipe_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.D_rs       = 5'd0;
    bus.D_rt       = 5'd0;
    bus.D_tuse_rs  = 2'd0;
    bus.D_tuse_rt  = 2'd0;
    bus.D_md       = 1'b0;
    bus.E_waddr    = 5'd0;
    bus.E_tnew     = 2'd0;
    bus.M_waddr    = 5'd0;
    bus.M_tnew     = 2'd0;
    bus.E_md_start = 1'b0;
    bus.E_md_div   = 1'b0;
  endtask

  task automatic check_stall(input string tag, input logic exp_stall);
    check({tag, ".F_WE"},  {31'd0, bus.F_WE},  {31'd0, !exp_stall});
    check({tag, ".D_WE"},  {31'd0, bus.D_WE},  {31'd0, !exp_stall});
    check({tag, ".E_clr"}, {31'd0, bus.E_clr}, {31'd0, exp_stall});
  endtask

  task automatic hazard(input string tag,
                        input logic [4:0] rs, input logic [1:0] tuse_rs,
                        input logic [4:0] rt, input logic [1:0] tuse_rt,
                        input logic [4:0] ew, input logic [1:0] etnew,
                        input logic [4:0] mw, input logic [1:0] mtnew,
                        input logic exp_stall);
    step();
    idle();
    bus.D_rs      = rs;
    bus.D_tuse_rs = tuse_rs;
    bus.D_rt      = rt;
    bus.D_tuse_rt = tuse_rt;
    bus.E_waddr   = ew;
    bus.E_tnew    = etnew;
    bus.M_waddr   = mw;
    bus.M_tnew    = mtnew;
    #1;
    check_stall(tag, exp_stall);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle();

    // Reset held with inputs that would otherwise stall and start a divide.
    step();
    bus.D_rs       = 5'd5;
    bus.E_waddr    = 5'd5;
    bus.E_tnew     = 2'd1;
    bus.D_md       = 1'b1;
    bus.E_md_start = 1'b1;
    bus.E_md_div   = 1'b1;
    #1;
    check_stall("rst_hold", 1'b0);
    check("rst_hold.md_busy", {31'd0, bus.md_busy}, 32'd0);
    step();
    step();
    reset = 1'b1;
    idle();
    #1;
    check_stall("rst_rel", 1'b0);
    check("rst_rel.md_busy", {31'd0, bus.md_busy}, 32'd0);
    check("rst_rel.stall_cnt", bus.stall_cnt, 32'd0);

    // Data hazards: rs/rt against E and M, address 0, Tnew vs Tuse edges.
    hazard("rs_e_hit",    5'd5, 2'd0, 5'd0, 2'd0, 5'd5, 2'd1, 5'd0, 2'd0, 1'b1);
    hazard("rs_zero",     5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd1, 5'd0, 2'd0, 1'b0);
    hazard("rs_e_eq",     5'd5, 2'd1, 5'd0, 2'd0, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0);
    hazard("rs_e_gt",     5'd5, 2'd1, 5'd0, 2'd0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b1);
    hazard("rt_m_hit",    5'd0, 2'd0, 5'd7, 2'd0, 5'd0, 2'd0, 5'd7, 2'd1, 1'b1);
    hazard("rt_m_eq",     5'd0, 2'd0, 5'd7, 2'd1, 5'd0, 2'd0, 5'd7, 2'd1, 1'b0);
    hazard("both_m_only", 5'd3, 2'd2, 5'd0, 2'd0, 5'd3, 2'd0, 5'd3, 2'd3, 1'b1);
    hazard("both_e_only", 5'd3, 2'd0, 5'd0, 2'd0, 5'd3, 2'd1, 5'd3, 2'd0, 1'b1);
    hazard("no_match",    5'd4, 2'd0, 5'd0, 2'd0, 5'd5, 2'd3, 5'd6, 2'd3, 1'b0);
    hazard("rt_zero",     5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0);
    step();
    idle();
    #1;
    check("hazard.stall_cnt", bus.stall_cnt, 32'd5);

    // Clear the counter before the multiply occupancy test.
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("clr.stall_cnt", bus.stall_cnt, 32'd0);

    // Multiply start with D_md held: stalls the start cycle plus 5 busy cycles.
    step();
    bus.D_md       = 1'b1;
    bus.E_md_start = 1'b1;
    bus.E_md_div   = 1'b0;
    #1;
    check_stall("mult_start", 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step();
      bus.E_md_start = 1'b0;
      #1;
      check($sformatf("mult_c%0d.md_busy", i), {31'd0, bus.md_busy}, {31'd0, i <= 5});
      check($sformatf("mult_c%0d.E_clr", i),   {31'd0, bus.E_clr},   {31'd0, i <= 5});
    end
    step();
    idle();
    #1;
    check("mult.stall_cnt", bus.stall_cnt, 32'd6);

    // Full divide without D_md: no stall, busy for exactly 10 cycles.
    step();
    bus.E_md_start = 1'b1;
    bus.E_md_div   = 1'b1;
    #1;
    check_stall("div_start_nomd", 1'b0);
    begin
      int n_busy;
      n_busy = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        idle();
        #1;
        if (bus.md_busy) n_busy++;
      end
      check("div.busy_cycles", n_busy, 32'd10);
    end

    // Divide restarted by a multiply three cycles later: 3 + 5 busy cycles.
    step();
    bus.E_md_start = 1'b1;
    bus.E_md_div   = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      bus.E_md_start = (i == 3);
      bus.E_md_div   = 1'b0;
      #1;
      check($sformatf("restart_c%0d.md_busy", i), {31'd0, bus.md_busy}, {31'd0, i <= 8});
    end

    // Reset asserted while the divide count sits at 7 aborts it.
    step();
    idle();
    bus.E_md_start = 1'b1;
    bus.E_md_div   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      idle();
      #1;
    end
    check("abort.busy_before", {31'd0, bus.md_busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort.busy_in_rst", {31'd0, bus.md_busy}, 32'd0);
    step();
    reset = 1'b1;
    bus.D_md = 1'b1;
    #1;
    check("abort.md_busy", {31'd0, bus.md_busy}, 32'd0);
    check("abort.stall_cnt", bus.stall_cnt, 32'd0);
    check_stall("abort.md_idle", 1'b0);

    // Saturation: preload near the top and keep stalling.
    step();
    idle();
    bus.D_rs    = 5'd9;
    bus.E_waddr = 5'd9;
    bus.E_tnew  = 2'd2;
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    #1;
    check("sat.preload", bus.stall_cnt, 32'hFFFF_FFFD);
    for (int i = 1; i <= 4; i++) begin
      step();
      #1;
      check($sformatf("sat_c%0d", i), bus.stall_cnt,
            (i == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
    end

    step();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
